// File: rtl/pad_host_sequencer.sv
// Host-side master for the SoC pad interface: queues WRITE/READ/EXEC commands,
// sequences the pad handshakes and returns READ data / EXEC status as responses.
module pad_host_sequencer #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int CMD_DEPTH    = 8,
  parameter int RD_TIMEOUT   = 255,
  parameter int EXEC_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              chip_en,
  output logic              data_addr_valid,
  output logic              read_write,
  output logic [ADDR_W-1:0] address_in,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_out_valid,
  output logic              scan_start_exec,
  output logic              trigger,
  input  logic              exec_end,
  output logic              busy
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int TMAX  = (RD_TIMEOUT > EXEC_TIMEOUT) ? RD_TIMEOUT : EXEC_TIMEOUT;
  localparam int CNT_W = $clog2(TMAX + 1) + 1;
  localparam int SAT_W = (CNT_W > DATA_W) ? CNT_W : DATA_W;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_EXEC  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR, RD_REQ, RD_WAIT, EX_TRIG, EX_WAIT, RSP
  } state_t;

  state_t state, state_next;

  logic [1:0]        op_mem   [CMD_DEPTH];
  logic [ADDR_W-1:0] addr_mem [CMD_DEPTH];
  logic [DATA_W-1:0] data_mem [CMD_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              empty, full, push, pop;
  logic [1:0]        head_op;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
  logic [SAT_W-1:0]  cnt_wide;
  logic [DATA_W-1:0] exec_count;

  logic              dav_next, rw_next, scan_next, trig_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] din_next;
  logic              rsp_valid_next, rsp_err_next;
  logic [DATA_W-1:0] rsp_data_next;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready = chip_en & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign head_op   = op_mem[rd_ptr[PTR_W-1:0]];
  assign head_addr = addr_mem[rd_ptr[PTR_W-1:0]];
  assign head_data = data_mem[rd_ptr[PTR_W-1:0]];
  assign busy      = (state != IDLE) | ~empty;

  assign cnt_inc    = cnt + 1'b1;
  assign cnt_wide   = SAT_W'(cnt_inc);
  assign exec_count = (cnt_wide > SAT_W'({DATA_W{1'b1}})) ? '1 : DATA_W'(cnt_wide);

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr[PTR_W-1:0]]   <= cmd_op;
      addr_mem[wr_ptr[PTR_W-1:0]] <= cmd_addr;
      data_mem[wr_ptr[PTR_W-1:0]] <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      chip_en <= 1'b0;
    end else begin
      chip_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Pad and response outputs are computed one state ahead so they leave a flop.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    pop            = 1'b0;
    dav_next       = 1'b0;
    rw_next        = 1'b0;
    addr_next      = '0;
    din_next       = '0;
    scan_next      = 1'b0;
    trig_next      = 1'b0;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data;
    rsp_err_next   = rsp_err;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          case (head_op)
            OP_WRITE: begin
              state_next = WR;
              dav_next   = 1'b1;
              rw_next    = 1'b1;
              addr_next  = head_addr;
              din_next   = head_data;
            end
            OP_READ: begin
              state_next = RD_REQ;
              dav_next   = 1'b1;
              addr_next  = head_addr;
            end
            OP_EXEC: begin
              state_next = EX_TRIG;
              scan_next  = 1'b1;
              trig_next  = 1'b1;
            end
            default: begin
              state_next     = RSP;
              rsp_valid_next = 1'b1;
              rsp_data_next  = '0;
              rsp_err_next   = 1'b1;
            end
          endcase
        end
      end
      WR: state_next = IDLE;
      RD_REQ: begin
        state_next = RD_WAIT;
        cnt_next   = '0;
      end
      RD_WAIT: begin
        if (data_out_valid) begin
          state_next     = RSP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = data_out;
          rsp_err_next   = 1'b0;
        end else if (cnt == CNT_W'(RD_TIMEOUT)) begin
          state_next     = RSP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = '0;
          rsp_err_next   = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      EX_TRIG: begin
        state_next = EX_WAIT;
        cnt_next   = '0;
        scan_next  = 1'b1;
      end
      EX_WAIT: begin
        // Reported count includes the cycle on which exec_end is seen.
        if (exec_end) begin
          state_next     = RSP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = exec_count;
          rsp_err_next   = 1'b0;
        end else if (cnt_inc == CNT_W'(EXEC_TIMEOUT)) begin
          state_next     = RSP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = '1;
          rsp_err_next   = 1'b1;
        end else begin
          scan_next = 1'b1;
          cnt_next  = cnt_inc;
        end
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
        else           rsp_valid_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      cnt             <= '0;
      data_addr_valid <= 1'b0;
      read_write      <= 1'b0;
      address_in      <= '0;
      data_in         <= '0;
      scan_start_exec <= 1'b0;
      trigger         <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      data_addr_valid <= dav_next;
      read_write      <= rw_next;
      address_in      <= addr_next;
      data_in         <= din_next;
      scan_start_exec <= scan_next;
      trigger         <= trig_next;
      rsp_valid       <= rsp_valid_next;
      rsp_data        <= rsp_data_next;
      rsp_err         <= rsp_err_next;
    end
  end

endmodule

// File: tb/tb_pad_host_sequencer.sv
// Directed bench for pad_host_sequencer: a small pad responder plus a monitor that
// logs strobes and responses; every expectation is a hand-computed constant.
module tb_pad_host_sequencer;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int RD_TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              chip_en, data_addr_valid, read_write;
  logic [ADDR_W-1:0] address_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out = '0;
  logic              data_out_valid = 1'b0;
  logic              scan_start_exec, trigger;
  logic              exec_end = 1'b0;
  logic              busy;

  pad_host_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(8),
    .RD_TIMEOUT(RD_TIMEOUT), .EXEC_TIMEOUT(65535)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .chip_en(chip_en), .data_addr_valid(data_addr_valid), .read_write(read_write),
    .address_in(address_in), .data_in(data_in),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .scan_start_exec(scan_start_exec), .trigger(trigger), .exec_end(exec_end),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Pad responder: answers reads from rd_q after rd_delay cycles, EXEC after ex_delay.
  int          rd_delay = 3;
  int          ex_delay = 0;
  int          rd_cd = 0;
  int          ex_cd = 0;
  logic [15:0] rd_q[$];
  logic [15:0] rd_hold = '0;

  always begin
    @(negedge clk);
    data_out_valid = 1'b0;
    exec_end       = 1'b0;
    data_out       = '0;
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) begin
        data_out_valid = 1'b1;
        data_out       = rd_hold;
      end
    end
    if (ex_cd > 0) begin
      ex_cd--;
      if (ex_cd == 0) exec_end = 1'b1;
    end
    if (data_addr_valid && !read_write && rd_q.size() > 0) begin
      rd_hold = rd_q.pop_front();
      rd_cd   = rd_delay;
    end
    if (trigger && ex_delay > 0) ex_cd = ex_delay;
  end

  // Monitor samples late in the low phase, after inputs have settled.
  logic [15:0] sa_q[$];
  logic [15:0] sd_q[$];
  logic        sr_q[$];
  int          sc_q[$];
  logic [16:0] rsp_q[$];
  int          rise_q[$];
  int          trig_cnt = 0;
  int          scan_cnt = 0;
  int          trig_cyc = 0;
  int          bus_bad = 0;
  logic        rsp_valid_d = 1'b0;

  always begin
    @(negedge clk);
    #3;
    if (data_addr_valid) begin
      sa_q.push_back(address_in);
      sd_q.push_back(data_in);
      sr_q.push_back(read_write);
      sc_q.push_back(cyc);
    end else if (address_in != '0 || data_in != '0) begin
      bus_bad++;
    end
    if (trigger) begin
      trig_cnt++;
      trig_cyc = cyc;
    end
    if (scan_start_exec) scan_cnt++;
    if (rsp_valid && !rsp_valid_d) rise_q.push_back(cyc);
    rsp_valid_d = rsp_valid;
    if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_err, rsp_data});
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) checkOutput("push_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input int limit);
    int n;
    n = 0;
    while (!rsp_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rsp_arrival", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_clear", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [15:0] exp_addr [8] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                                16'h0104, 16'h0106, 16'h0107, 16'h0108};
  logic [15:0] exp_data [8] = '{16'h0000, 16'h1111, 16'h2222, 16'h0000,
                                16'h4444, 16'h6666, 16'h7777, 16'h8888};
  logic        exp_rw   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int sbase, rbase, tbase, scbase;

    repeat (2) @(negedge clk);
    checkOutput("reset_outputs",
                {24'd0, chip_en, cmd_ready, rsp_valid, busy, data_addr_valid,
                 scan_start_exec, trigger, read_write}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("chip_en_after_reset", {31'd0, chip_en}, 32'd1);
    checkOutput("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // WRITE: single strobe, no response
    sbase = sa_q.size();
    rbase = rsp_q.size();
    applyStimulus(2'b00, 16'h0010, 16'hBEEF);
    waitIdle(50);
    @(negedge clk);
    checkOutput("wr_strobe_count", sa_q.size() - sbase, 32'd1);
    if (sa_q.size() > sbase) begin
      checkOutput("wr_rw", {31'd0, sr_q[sbase]}, 32'd1);
      checkOutput("wr_addr", {16'd0, sa_q[sbase]}, 32'h0010);
      checkOutput("wr_data", {16'd0, sd_q[sbase]}, 32'hBEEF);
    end
    checkOutput("wr_no_rsp", rsp_q.size() - rbase, 32'd0);

    // READ with response held for 5 cycles under backpressure
    rd_q.push_back(16'h1234);
    rd_delay  = 3;
    rsp_ready = 1'b0;
    applyStimulus(2'b01, 16'h0020, 16'h0000);
    waitRsp(50);
    for (int i = 0; i < 5; i++) begin
      checkOutput("rd_hold_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("rd_hold_data", {15'd0, rsp_err, rsp_data}, 32'h0000_1234);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("rd_valid_drop", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rd_strobe_addr", {16'd0, sa_q[$]}, 32'h0020);
    checkOutput("rd_strobe_rw", {31'd0, sr_q[$]}, 32'd0);
    checkOutput("rd_latency", rise_q[$] - sc_q[$], 32'd4);
    checkOutput("rd_rsp_logged", {15'd0, rsp_q[$]}, 32'h0000_1234);

    // READ where data_out_valid lands exactly on the timeout cycle: data wins
    rd_q.push_back(16'h0F0F);
    rd_delay = RD_TIMEOUT + 1;
    applyStimulus(2'b01, 16'h0040, 16'h0000);
    waitRsp(400);
    @(negedge clk);
    checkOutput("rd_edge_rsp", {15'd0, rsp_q[$]}, 32'h0000_0F0F);
    checkOutput("rd_edge_latency", rise_q[$] - sc_q[$], RD_TIMEOUT + 2);

    // READ timeout; the late data_out_valid arrives as a stray and is ignored
    rd_q.push_back(16'hDEAD);
    rd_delay = RD_TIMEOUT + 2;
    rbase = rsp_q.size();
    applyStimulus(2'b01, 16'h0030, 16'h0000);
    waitRsp(400);
    repeat (6) @(negedge clk);
    checkOutput("rd_timeout_rsp", {15'd0, rsp_q[$]}, 32'h0001_0000);
    checkOutput("rd_timeout_latency", rise_q[$] - sc_q[$], RD_TIMEOUT + 2);
    checkOutput("rd_timeout_single_rsp", rsp_q.size() - rbase, 32'd1);
    checkOutput("rd_timeout_idle", {31'd0, busy}, 32'd0);

    // EXEC finishing 100 cycles after trigger
    ex_delay = 100;
    tbase  = trig_cnt;
    scbase = scan_cnt;
    applyStimulus(2'b10, 16'h0000, 16'h0000);
    waitRsp(300);
    @(negedge clk);
    checkOutput("ex_trigger_pulses", trig_cnt - tbase, 32'd1);
    checkOutput("ex_scan_cycles", scan_cnt - scbase, 32'd101);
    checkOutput("ex_rsp", {15'd0, rsp_q[$]}, 32'd100);
    checkOutput("ex_latency", rise_q[$] - trig_cyc, 32'd101);
    checkOutput("ex_scan_low_after", {31'd0, scan_start_exec}, 32'd0);

    // Nine commands against an 8-deep FIFO while the first READ stalls the pad
    rd_q.push_back(16'hCAFE);
    rd_q.push_back(16'hBEAD);
    rd_delay = 40;
    ex_delay = 0;
    sbase = sa_q.size();
    rbase = rsp_q.size();
    applyStimulus(2'b01, 16'h0100, 16'h0000);
    applyStimulus(2'b00, 16'h0101, 16'h1111);
    applyStimulus(2'b00, 16'h0102, 16'h2222);
    applyStimulus(2'b01, 16'h0103, 16'h0000);
    applyStimulus(2'b00, 16'h0104, 16'h4444);
    applyStimulus(2'b11, 16'h0105, 16'h5555);
    applyStimulus(2'b00, 16'h0106, 16'h6666);
    applyStimulus(2'b00, 16'h0107, 16'h7777);
    applyStimulus(2'b00, 16'h0108, 16'h8888);
    checkOutput("fifo_full_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("fifo_full_busy", {31'd0, busy}, 32'd1);
    waitIdle(1000);
    @(negedge clk);
    checkOutput("batch_strobe_count", sa_q.size() - sbase, 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (sa_q.size() > sbase + i) begin
        checkOutput("batch_addr", {16'd0, sa_q[sbase+i]}, {16'd0, exp_addr[i]});
        checkOutput("batch_data", {16'd0, sd_q[sbase+i]}, {16'd0, exp_data[i]});
        checkOutput("batch_rw", {31'd0, sr_q[sbase+i]}, {31'd0, exp_rw[i]});
      end
    end
    checkOutput("batch_rsp_count", rsp_q.size() - rbase, 32'd3);
    if (rsp_q.size() >= rbase + 3) begin
      checkOutput("batch_rsp0", {15'd0, rsp_q[rbase]}, 32'h0000_CAFE);
      checkOutput("batch_rsp1", {15'd0, rsp_q[rbase+1]}, 32'h0000_BEAD);
      checkOutput("batch_rsp_reserved", {15'd0, rsp_q[rbase+2]}, 32'h0001_0000);
    end

    // Asynchronous reset in the middle of EX_WAIT
    ex_delay = 0;
    applyStimulus(2'b10, 16'h0000, 16'h0000);
    repeat (20) @(negedge clk);
    checkOutput("ex_wait_scan", {31'd0, scan_start_exec}, 32'd1);
    rbase = rsp_q.size();
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {24'd0, chip_en, cmd_ready, rsp_valid, busy, data_addr_valid,
                 scan_start_exec, trigger, read_write}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_chip_en", {31'd0, chip_en}, 32'd1);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("post_reset_no_rsp", rsp_q.size() - rbase, 32'd0);
    checkOutput("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    checkOutput("bus_zero_when_idle", bus_bad, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
